instr_sequencer: RTL and testbench

- Hardwired FSM controller for the 4-bit accumulator datapath: PC, MAR, RAM, IR, A, TMP, B, ALU and OUT.
- Replaces the free-running ring counter with an explicit fetch/execute state machine.
- Adds run/single-step control, halt, illegal-opcode detection and an instruction counter.
- Drives the 18-bit control word consumed by the datapath registers.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/instr_decode.sv | 73 +++++++
 rtl/instr_sequencer.sv | 112 +++++++++++
 tb/tb_instr_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU: opcodes, control-word bit
// positions and the sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_XCHG = 4'b0011;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_HLT  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    // Control word bit positions, LSB first
    localparam int CB_CP    = 0;
    localparam int CB_EP    = 1;
    localparam int CB_LMP   = 2;
    localparam int CB_LMI   = 3;
    localparam int CB_CEI   = 4;
    localparam int CB_CEA   = 5;
    localparam int CB_LI    = 6;
    localparam int CB_EI    = 7;
    localparam int CB_LARAM = 8;
    localparam int CB_LAB   = 9;
    localparam int CB_EATMP = 10;
    localparam int CB_SU    = 11;
    localparam int CB_EU    = 12;
    localparam int CB_LBTMP = 13;
    localparam int CB_EBA   = 14;
    localparam int CB_LO    = 15;
    localparam int CB_LTMPA = 16;
    localparam int CB_ETMPB = 17;

    // T1..T6 are numbered so the one-hot T-state bit is (state - 1)
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        WAIT = 4'd7,
        HALT = 4'd8
    } state_t;

    function automatic logic opcode_legal(input logic [3:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_XCHG, OP_MOV, OP_HLT, OP_OUT: opcode_legal = 1'b1;
            default:                                                  opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational control-word decoder: (state, opcode) -> control word.
// Fetch states ignore the opcode; undefined opcodes decode as NOP.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int CTRLW = 18
) (
    input  state_t           state,
    input  logic [OPW-1:0]   opcode,
    output logic [CTRLW-1:0] ctrl_word
);

    always_comb begin
        ctrl_word = '0;
        case (state)
            T1: begin
                ctrl_word[CB_EP]  = 1'b1;
                ctrl_word[CB_LMP] = 1'b1;
            end
            T2: ctrl_word[CB_CP] = 1'b1;
            T3: begin
                ctrl_word[CB_CEI] = 1'b1;
                ctrl_word[CB_LI]  = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_MOV: begin
                        ctrl_word[CB_LMI] = 1'b1;
                        ctrl_word[CB_EI]  = 1'b1;
                    end
                    OP_XCHG: begin
                        ctrl_word[CB_EATMP] = 1'b1;
                        ctrl_word[CB_LTMPA] = 1'b1;
                    end
                    OP_ADD: ctrl_word[CB_EBA] = 1'b1;
                    OP_SUB: begin
                        ctrl_word[CB_EBA] = 1'b1;
                        ctrl_word[CB_SU]  = 1'b1;
                    end
                    OP_OUT:  ctrl_word[CB_LO] = 1'b1;
                    default: ctrl_word = '0;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_MOV: begin
                        ctrl_word[CB_CEA]   = 1'b1;
                        ctrl_word[CB_LARAM] = 1'b1;
                    end
                    OP_XCHG: begin
                        ctrl_word[CB_LAB] = 1'b1;
                        ctrl_word[CB_EBA] = 1'b1;
                    end
                    OP_ADD: ctrl_word[CB_EU] = 1'b1;
                    OP_SUB: begin
                        ctrl_word[CB_SU] = 1'b1;
                        ctrl_word[CB_EU] = 1'b1;
                    end
                    default: ctrl_word = '0;
                endcase
            end
            T6: begin
                if (opcode == OP_XCHG) begin
                    ctrl_word[CB_LBTMP] = 1'b1;
                    ctrl_word[CB_ETMPB] = 1'b1;
                end
            end
            default: ctrl_word = '0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the accumulator CPU: run/single-step control,
// halt, illegal-opcode flag, retired-instruction counter and registered control word.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int CTRLW = 18,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [OPW-1:0]   ir_opcode,
    output logic [CTRLW-1:0] ctrl_word,
    output logic [5:0]       t_state,
    output logic             instr_done,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNTW-1:0]  instr_count
);

    state_t           state_reg, state_next;
    logic [OPW-1:0]   op_q_reg;
    logic [OPW-1:0]   dec_opcode;
    logic             step_prev_reg;
    logic             step_rise;
    logic [CTRLW-1:0] ctrl_reg, ctrl_next;
    logic [5:0]       t_state_reg, t_state_next;
    logic             done_reg;
    logic             halted_reg;
    logic             illegal_reg;
    logic [CNTW-1:0]  count_reg;
    logic             retire;

    assign step_rise = step & ~step_prev_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, WAIT: if (run || step_rise) state_next = T1;
            T1:         state_next = T2;
            T2:         state_next = T3;
            T3:         state_next = (ir_opcode == OP_HLT) ? HALT : T4;
            T4:         state_next = T5;
            T5:         state_next = T6;
            T6:         state_next = run ? T1 : WAIT;
            HALT:       state_next = HALT;
            default:    state_next = IDLE;
        endcase
    end

    // HLT retires on its way into HALT since it never reaches T6
    assign retire = (state_reg == T6) || ((state_reg == T3) && (state_next == HALT));

    // T4 decodes the live IR; T5/T6 use the copy latched on entry to T4
    assign dec_opcode = (state_reg == T3) ? ir_opcode : op_q_reg;

    instr_decode #(
        .OPW   (OPW),
        .CTRLW (CTRLW)
    ) u_decode (
        .state     (state_next),
        .opcode    (dec_opcode),
        .ctrl_word (ctrl_next)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_tstate
            assign t_state_next[gi] = (state_next == state_t'(4'(gi + 1)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            op_q_reg      <= '0;
            step_prev_reg <= 1'b0;
            ctrl_reg      <= '0;
            t_state_reg   <= '0;
            done_reg      <= 1'b0;
            halted_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            step_prev_reg <= step;
            ctrl_reg      <= ctrl_next;
            t_state_reg   <= t_state_next;
            done_reg      <= (state_reg == T6);
            halted_reg    <= (state_next == HALT);
            if (state_reg == T3) begin
                op_q_reg <= ir_opcode;
            end
            if ((state_reg == T3) && (state_next == T4) && !opcode_legal(ir_opcode)) begin
                illegal_reg <= 1'b1;
            end
            if (retire) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign ctrl_word   = ctrl_reg;
    assign t_state     = t_state_reg;
    assign instr_done  = done_reg;
    assign halted      = halted_reg;
    assign illegal_op  = illegal_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Table-driven bench for instr_sequencer plus hand-written step and halt sequences.
module tb_instr_sequencer;

    localparam logic [17:0] CP    = 18'd1 << 0;
    localparam logic [17:0] EP    = 18'd1 << 1;
    localparam logic [17:0] LMP   = 18'd1 << 2;
    localparam logic [17:0] LMI   = 18'd1 << 3;
    localparam logic [17:0] CEI   = 18'd1 << 4;
    localparam logic [17:0] CEA   = 18'd1 << 5;
    localparam logic [17:0] LI    = 18'd1 << 6;
    localparam logic [17:0] EI    = 18'd1 << 7;
    localparam logic [17:0] LARAM = 18'd1 << 8;
    localparam logic [17:0] LAB   = 18'd1 << 9;
    localparam logic [17:0] EATMP = 18'd1 << 10;
    localparam logic [17:0] SU    = 18'd1 << 11;
    localparam logic [17:0] EU    = 18'd1 << 12;
    localparam logic [17:0] LBTMP = 18'd1 << 13;
    localparam logic [17:0] EBA   = 18'd1 << 14;
    localparam logic [17:0] LO    = 18'd1 << 15;
    localparam logic [17:0] LTMPA = 18'd1 << 16;
    localparam logic [17:0] ETMPB = 18'd1 << 17;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [3:0]  ir_opcode;
    logic [17:0] ctrl_word;
    logic [5:0]  t_state;
    logic        instr_done;
    logic        halted;
    logic        illegal_op;
    logic [7:0]  instr_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        step;
        logic [3:0]  op;
        logic [5:0]  t;
        logic [17:0] ctrl;
        logic        done;
        logic        ill;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    instr_sequencer #(.OPW(4), .CTRLW(18), .CNTW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .ir_opcode   (ir_opcode),
        .ctrl_word   (ctrl_word),
        .t_state     (t_state),
        .instr_done  (instr_done),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] onehot(input int n);
        logic [5:0] r;
        r = '0;
        if (n >= 1 && n <= 6) r[n-1] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic r, input logic s, input logic [3:0] op,
                       input int tn, input logic [17:0] ctrl, input logic done,
                       input logic ill, input int cnt);
        vec_t v;
        v.rst  = rst;
        v.run  = r;
        v.step = s;
        v.op   = op;
        v.t    = onehot(tn);
        v.ctrl = ctrl;
        v.done = done;
        v.ill  = ill;
        v.cnt  = 8'(cnt);
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [17:0] mov_c [6];
        int step_a [9];
        int step_b [9];
        int texp   [9];
        int done_cnt;

        reset = 1'b1; run = 1'b0; step = 1'b0; ir_opcode = 4'b0000;
        mov_c = '{EP | LMP, CP, CEI | LI, LMI | EI, CEA | LARAM, 18'd0};

        // Reset
        add(1, 0, 0, 4'b0000, 0, 18'd0, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 0, 18'd0, 0, 0, 0);
        // MOV back-to-back, three instructions, no bubble
        for (int k = 0; k < 3; k++)
            for (int t = 1; t <= 6; t++)
                add(0, 1, 0, 4'b0111, t, mov_c[t-1], (k > 0 && t == 1), 0, k);
        add(0, 1, 0, 4'b0011, 1, EP | LMP, 1, 0, 3);
        // XCHG; opcode changed to ADD during T5 must not disturb T6
        add(0, 1, 0, 4'b0011, 2, CP, 0, 0, 3);
        add(0, 1, 0, 4'b0011, 3, CEI | LI, 0, 0, 3);
        add(0, 1, 0, 4'b0011, 4, EATMP | LTMPA, 0, 0, 3);
        add(0, 1, 0, 4'b0011, 5, LAB | EBA, 0, 0, 3);
        add(0, 1, 0, 4'b0001, 6, LBTMP | ETMPB, 0, 0, 3);
        add(0, 1, 0, 4'b0001, 1, EP | LMP, 1, 0, 4);
        // ADD
        add(0, 1, 0, 4'b0001, 2, CP, 0, 0, 4);
        add(0, 1, 0, 4'b0001, 3, CEI | LI, 0, 0, 4);
        add(0, 1, 0, 4'b0001, 4, EBA, 0, 0, 4);
        add(0, 1, 0, 4'b0001, 5, EU, 0, 0, 4);
        add(0, 1, 0, 4'b0010, 6, 18'd0, 0, 0, 4);
        add(0, 1, 0, 4'b0010, 1, EP | LMP, 1, 0, 5);
        // SUB with run dropped mid-instruction: completes, then WAIT
        add(0, 1, 0, 4'b0010, 2, CP, 0, 0, 5);
        add(0, 1, 0, 4'b0010, 3, CEI | LI, 0, 0, 5);
        add(0, 0, 0, 4'b0010, 4, EBA | SU, 0, 0, 5);
        add(0, 0, 0, 4'b0010, 5, SU | EU, 0, 0, 5);
        add(0, 0, 0, 4'b0010, 6, 18'd0, 0, 0, 5);
        add(0, 0, 0, 4'b0010, 0, 18'd0, 1, 0, 6);
        add(0, 0, 0, 4'b0010, 0, 18'd0, 0, 0, 6);
        // Undefined opcode 0101: NOP behaviour, sticky flag from T4
        add(0, 1, 0, 4'b0101, 1, EP | LMP, 0, 0, 6);
        add(0, 1, 0, 4'b0101, 2, CP, 0, 0, 6);
        add(0, 1, 0, 4'b0101, 3, CEI | LI, 0, 0, 6);
        add(0, 1, 0, 4'b0101, 4, 18'd0, 0, 1, 6);
        add(0, 1, 0, 4'b0101, 5, 18'd0, 0, 1, 6);
        add(0, 1, 0, 4'b0001, 6, 18'd0, 0, 1, 6);
        add(0, 1, 0, 4'b0001, 1, EP | LMP, 1, 1, 7);
        add(0, 1, 0, 4'b0001, 2, CP, 0, 1, 7);
        add(0, 1, 0, 4'b0001, 3, CEI | LI, 0, 1, 7);
        add(0, 1, 0, 4'b0001, 4, EBA, 0, 1, 7);
        add(0, 1, 0, 4'b0001, 5, EU, 0, 1, 7);
        // Reset during T5 aborts; nothing retires
        add(1, 1, 0, 4'b0001, 0, 18'd0, 0, 0, 0);
        add(0, 0, 0, 4'b0001, 0, 18'd0, 0, 0, 0);
        add(0, 0, 0, 4'b0001, 0, 18'd0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            run       = vecs[i].run;
            step      = vecs[i].step;
            ir_opcode = vecs[i].op;
            tick();
            $display("vec %0d: rst=%0b run=%0b op=%b -> t=%b ctrl=%05h done=%0b ill=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].run, vecs[i].op, t_state, ctrl_word,
                     instr_done, illegal_op, instr_count);
            chk($sformatf("vec%0d t_state", i), 32'(t_state), 32'(vecs[i].t));
            chk($sformatf("vec%0d ctrl_word", i), 32'(ctrl_word), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d instr_done", i), 32'(instr_done), 32'(vecs[i].done));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'd0);
            chk($sformatf("vec%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
            chk($sformatf("vec%0d instr_count", i), 32'(instr_count), 32'(vecs[i].cnt));
        end

        // Single step: step held 5 cycles runs exactly one OUT instruction
        run = 1'b0; ir_opcode = 4'b1111;
        step_a = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        texp   = '{1, 2, 3, 4, 5, 6, 0, 0, 0};
        done_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            step = step_a[c][0];
            tick();
            $display("step1 cyc %0d: step=%0b t=%b ctrl=%05h done=%0b", c, step, t_state, ctrl_word, instr_done);
            chk($sformatf("step1 c%0d t_state", c), 32'(t_state), 32'(onehot(texp[c])));
            if (texp[c] == 4) chk("step1 T4 ctrl Lo", 32'(ctrl_word), 32'(LO));
            done_cnt += int'(instr_done);
        end
        chk("step1 done pulses", 32'(done_cnt), 32'd1);
        chk("step1 instr_count", 32'(instr_count), 32'd1);

        // Second step starts the next one; an edge during the instruction is not queued
        step_b = '{1, 0, 1, 1, 1, 1, 1, 1, 1};
        done_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            step = step_b[c][0];
            tick();
            $display("step2 cyc %0d: step=%0b t=%b ctrl=%05h done=%0b", c, step, t_state, ctrl_word, instr_done);
            chk($sformatf("step2 c%0d t_state", c), 32'(t_state), 32'(onehot(texp[c])));
            done_cnt += int'(instr_done);
        end
        chk("step2 done pulses", 32'(done_cnt), 32'd1);
        chk("step2 instr_count", 32'(instr_count), 32'd2);

        // HLT: fetch then HALT, counted, absorbing until reset
        step = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b1; ir_opcode = 4'b1110;
        for (int c = 1; c <= 3; c++) begin
            tick();
            $display("hlt fetch T%0d: t=%b ctrl=%05h", c, t_state, ctrl_word);
            chk($sformatf("hlt T%0d t_state", c), 32'(t_state), 32'(onehot(c)));
        end
        tick();
        $display("hlt enter: t=%b ctrl=%05h halted=%0b cnt=%0d", t_state, ctrl_word, halted, instr_count);
        chk("hlt halted", 32'(halted), 32'd1);
        chk("hlt ctrl_word", 32'(ctrl_word), 32'd0);
        chk("hlt t_state", 32'(t_state), 32'd0);
        chk("hlt instr_count", 32'(instr_count), 32'd1);
        for (int c = 0; c < 6; c++) begin
            run  = c[0];
            step = c[1];
            ir_opcode = 4'b0111;
            tick();
            $display("hlt hold %0d: run=%0b step=%0b t=%b halted=%0b cnt=%0d", c, run, step, t_state, halted, instr_count);
            chk($sformatf("hlt hold%0d halted", c), 32'(halted), 32'd1);
            chk($sformatf("hlt hold%0d t_state", c), 32'(t_state), 32'd0);
            chk($sformatf("hlt hold%0d count", c), 32'(instr_count), 32'd1);
        end
        reset = 1'b1; run = 1'b0; step = 1'b0;
        tick();
        $display("hlt reset: halted=%0b cnt=%0d t=%b", halted, instr_count, t_state);
        chk("hlt reset halted", 32'(halted), 32'd0);
        chk("hlt reset count", 32'(instr_count), 32'd0);
        chk("hlt reset t_state", 32'(t_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
